vote_input_conditioner: RTL and testbench
=========================================

Name: vote_input_conditioner

Overview:
- Upstream stage of the 3-input `minority` gate.
- Takes three raw, asynchronous inputs (switches or pins) and passes each through a synchronizer and a per-channel debounce filter.
- Drives stable, glitch-free `a`, `b`, `c` into the `minority` inputs.
- Also flags when the conditioned vector is valid and when it changes, so downstream logic samples `y` only on settled inputs.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in each input synchronizer chain; legal values are 2 or more.
- DEBOUNCE_CYCLES, 4, number of consecutive cycles a synchronized input must differ from the held value before the held value updates; legal values are 1 or more (1 means no filtering).
- CNT_W, local, equal to $clog2(DEBOUNCE_CYCLES+SYNC_STAGES+1); width of all counters; not overridable.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- raw_a  input  1  raw asynchronous input, channel a.
- raw_b  input  1  raw asynchronous input, channel b.
- raw_c  input  1  raw asynchronous input, channel c.
- a  output  1  conditioned channel a, connects to `minority.a`.
- b  output  1  conditioned channel b, connects to `minority.b`.
- c  output  1  conditioned channel c, connects to `minority.c`.
- valid  output  1  high once the warm-up after reset has completed; stays high until the next reset.
- change  output  1  one-cycle pulse, high in the cycle in which any of `a`, `b`, `c` takes a new value.

Behaviour:
- Reset (`rst_n` = 0, asynchronous):
  - All synchronizer flops, debounce counters and the warm-up counter go to 0.
  - Outputs reset to `a`=`b`=`c`=0, `valid`=0, `change`=0.
  - Downstream `y` therefore reads 1 during reset.
- Reset release is synchronous to `clk`. Reset asserted mid-operation aborts any debounce in progress and any pending change.
- Synchronizer: each raw input feeds its own SYNC_STAGES-deep flop chain; `s_x` is the last stage of the chain.
- Debounce, per channel, evaluated on every rising edge:
  - If `s_x` equals the held output: counter goes to 0.
  - If `s_x` differs and counter equals DEBOUNCE_CYCLES-1: the held output takes the value of `s_x`, and the counter goes to 0.
  - If `s_x` differs and counter is below DEBOUNCE_CYCLES-1: counter increments by 1.
- Latency, L = SYNC_STAGES + DEBOUNCE_CYCLES:
  - A raw level held constant updates the output on the L-th rising edge, counting the first edge that samples it as edge 1.
  - With defaults, L = 6.
- Glitch rejection: a mismatch at `s_x` lasting fewer than DEBOUNCE_CYCLES consecutive edges clears the counter and leaves the output unchanged.
- Multiple channels: each channel is fully independent. Simultaneous updates on several channels produce a single `change` pulse.
- change: registered, asserted in the same cycle the new `a`/`b`/`c` values first appear, and deasserted on the next edge unless another update occurs.
- valid:
  - The warm-up counter increments each edge after reset release.
  - `valid` goes to 1 on the L-th edge after reset release and saturates at 1.
  - `change` pulses are produced whether or not `valid` is high.
- No combinational path from `raw_*` to any output; every output is a flop output.

Optional Feature:
- Macro: VOTE_COND_HOLD_EN.
- Defined:
  - Adds input port `hold` (1 bit), placed after the `raw_c` port.
  - While `hold`=1, `a`/`b`/`c` do not update and `change` stays 0.
  - While `hold`=1, debounce counters still count but saturate at DEBOUNCE_CYCLES-1.
  - If a mismatch still persists when `hold` falls, the output updates on the first edge after `hold` falls.
  - The `hold` input itself is sampled with no synchronizer; it must be synchronous to `clk`.
- Undefined: the `hold` port is absent and behaviour is exactly as described in Behaviour.

Test Plan:
- Reset and warm-up: assert `rst_n`=0 with `raw`=111, then release → `a`=`b`=`c`=0, `valid`=0, and downstream `y`=1 during reset; `valid` rises on edge 6 after release.
- Clean step, defaults: hold `raw_a` from 0 to 1 constant → `a`=1 on the 6th sampling edge and not before; one `change` pulse; `y` goes 1→1 for `bc`=00.
- Glitch rejection: pulse `raw_b` high for 3 cycles, then low → `b` stays 0 and `change` never asserts; repeat with 4 cycles → `b`=1 after L edges.
- Simultaneous update: toggle `raw` 000→011 in the same cycle → `b`,`c` update on the same edge; exactly one `change` pulse; `y`=0.
- Reset mid-debounce: change `raw_c` to 1, then assert `rst_n`=0 after 4 edges → `c`=0 immediately; after release with `raw_c`=1 held, `c`=1 only after a full 6 edges.
- With VOTE_COND_HOLD_EN: set `hold`=1, change `raw_a` to 1, wait 10 cycles → `a`=0; drop `hold` → `a`=1 on the next edge with one `change` pulse.

Source files
------------

// File: rtl/vote_input_conditioner.sv
// Conditions three raw asynchronous inputs (synchronizer + per-channel debounce) for the minority gate.
// Optional VOTE_COND_HOLD_EN adds a synchronous `hold` input that freezes the conditioned outputs.
module vote_input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_a,
    input  logic raw_b,
    input  logic raw_c,
`ifdef VOTE_COND_HOLD_EN
    input  logic hold,
`endif
    output logic a,
    output logic b,
    output logic c,
    output logic valid,
    output logic change
);

    localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + SYNC_STAGES + 1);
    localparam int LATENCY = SYNC_STAGES + DEBOUNCE_CYCLES;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Channel order within the vectors: bit 2 = a, bit 1 = b, bit 0 = c.
    logic [2:0] raw_vec;
    logic [2:0] held_vec;
    logic [2:0] upd_vec;
    logic       hold_w;

    logic             change_q, change_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] warm_q, warm_d;

    assign raw_vec = {raw_a, raw_b, raw_c};

`ifdef VOTE_COND_HOLD_EN
    assign hold_w = hold;
`else
    assign hold_w = 1'b0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            logic [SYNC_STAGES-1:0] sync_q, sync_d;
            logic [CNT_W-1:0]       cnt_q, cnt_d;
            logic                   held_q, held_d;
            logic                   upd_d;
            logic                   s_x;

            assign sync_d = {sync_q[SYNC_STAGES-2:0], raw_vec[gi]};
            assign s_x    = sync_q[SYNC_STAGES-1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= sync_d;
                end
            end

            // While held, a persistent mismatch parks the counter at its last
            // value so the update fires on the first edge after hold drops.
            always_comb begin
                cnt_d  = cnt_q;
                held_d = held_q;
                upd_d  = 1'b0;
                if (s_x == held_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    if (!hold_w) begin
                        held_d = s_x;
                        cnt_d  = '0;
                        upd_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q  <= '0;
                    held_q <= 1'b0;
                end else begin
                    cnt_q  <= cnt_d;
                    held_q <= held_d;
                end
            end

            assign held_vec[gi] = held_q;
            assign upd_vec[gi]  = upd_d;
        end
    endgenerate

    // One pulse regardless of how many channels update on the same edge.
    assign change_d = |upd_vec;

    assign warm_d  = valid_q ? warm_q : (warm_q + CNT_ONE);
    assign valid_d = valid_q | (warm_q == WARM_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            change_q <= 1'b0;
            valid_q  <= 1'b0;
            warm_q   <= '0;
        end else begin
            change_q <= change_d;
            valid_q  <= valid_d;
            warm_q   <= warm_d;
        end
    end

    assign a      = held_vec[2];
    assign b      = held_vec[1];
    assign c      = held_vec[0];
    assign valid  = valid_q;
    assign change = change_q;

endmodule

// File: tb/tb_vote_input_conditioner.sv
// Directed scoreboard bench for vote_input_conditioner (default parameters, L = 6).
// Build with VOTE_COND_HOLD_EN defined to also exercise the hold input.
module tb_vote_input_conditioner;

    localparam int LAT = 6;

    logic clk = 1'b0;
    logic rst_n;
    logic raw_a, raw_b, raw_c;
    logic a, b, c, valid, change;
`ifdef VOTE_COND_HOLD_EN
    logic hold;
`endif

    always #5 clk = ~clk;

    vote_input_conditioner dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_a  (raw_a),
        .raw_b  (raw_b),
        .raw_c  (raw_c),
`ifdef VOTE_COND_HOLD_EN
        .hold   (hold),
`endif
        .a      (a),
        .b      (b),
        .c      (c),
        .valid  (valid),
        .change (change)
    );

    typedef struct {
        string      tag;
        logic [2:0] abc;
        logic       chg;
        logic       vld;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Downstream minority gate: 1 when at most one input is high.
    function automatic logic minority3(input logic [2:0] v);
        return ~((v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]));
    endfunction

    task automatic push_exp(input string tag, input logic [2:0] abc, input logic chg, input logic vld);
        exp_t e;
        e.tag = tag;
        e.abc = abc;
        e.chg = chg;
        e.vld = vld;
        sb.push_back(e);
    endtask

    // Expectations for edges 1..n after a stimulus change: output moves from
    // old_v to new_v on edge upd (0 = never), valid is high from edge vld_from.
    task automatic push_window(input string tag, input logic [2:0] old_v, input logic [2:0] new_v,
                               input int upd, input int n, input int vld_from);
        for (int k = 1; k <= n; k++) begin
            push_exp(tag, (upd != 0 && k >= upd) ? new_v : old_v, (k == upd), (k >= vld_from));
        end
    endtask

    task automatic compare_front();
        exp_t       e;
        logic [2:0] obs;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard_empty: observed abc=%b change=%b, required a queued expectation", {a, b, c}, change);
        end
        if (sb.size() != 0) begin
            e   = sb.pop_front();
            obs = {a, b, c};
            checks++;
            assert (obs === e.abc) else begin
                errors++;
                $error("FAIL %s abc: observed %b expected %b", e.tag, obs, e.abc);
            end
            checks++;
            assert (change === e.chg) else begin
                errors++;
                $error("FAIL %s change: observed %b expected %b", e.tag, change, e.chg);
            end
            checks++;
            assert (valid === e.vld) else begin
                errors++;
                $error("FAIL %s valid: observed %b expected %b", e.tag, valid, e.vld);
            end
            checks++;
            assert (minority3(obs) === minority3(e.abc)) else begin
                errors++;
                $error("FAIL %s y: observed %b expected %b", e.tag, minority3(obs), minority3(e.abc));
            end
            $display("step %-14s abc=%b change=%b valid=%b y=%b", e.tag, obs, change, valid, minority3(obs));
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            compare_front();
        end
    endtask

    task automatic set_raw(input logic [2:0] v);
        raw_a = v[2];
        raw_b = v[1];
        raw_c = v[0];
    endtask

    initial begin
        rst_n = 1'b1;
        set_raw(3'b111);
`ifdef VOTE_COND_HOLD_EN
        hold = 1'b0;
`endif
        #1 rst_n = 1'b0;

        // Reset state with raw = 111
        @(negedge clk);
        push_exp("reset", 3'b000, 1'b0, 1'b0);
        compare_front();
        @(negedge clk);
        push_exp("reset", 3'b000, 1'b0, 1'b0);
        compare_front();

        // Release: raw 111 propagates and valid rises together on edge 6
        rst_n = 1'b1;
        push_window("warmup", 3'b000, 3'b111, LAT, LAT + 1, LAT);
        tick(LAT + 1);

        set_raw(3'b000);
        push_window("clear", 3'b111, 3'b000, LAT, LAT + 1, 1);
        tick(LAT + 1);

        // Clean step on a
        set_raw(3'b100);
        push_window("step_a", 3'b000, 3'b100, LAT, LAT + 1, 1);
        tick(LAT + 1);

        // 3-cycle glitch on b is rejected
        push_window("glitch3", 3'b100, 3'b100, 0, 11, 1);
        raw_b = 1'b1;
        tick(3);
        raw_b = 1'b0;
        tick(8);

        // 4-cycle pulse on b passes, then debounces back to 0
        push_window("glitch4", 3'b100, 3'b110, LAT, 9, 1);
        push_window("glitch4_back", 3'b110, 3'b100, 1, 2, 1);
        raw_b = 1'b1;
        tick(4);
        raw_b = 1'b0;
        tick(7);

        set_raw(3'b000);
        push_window("clear_a", 3'b100, 3'b000, LAT, LAT + 1, 1);
        tick(LAT + 1);

        // Simultaneous update of b and c: one change pulse, y = 0
        set_raw(3'b011);
        push_window("simul", 3'b000, 3'b011, LAT, LAT + 1, 1);
        tick(LAT + 1);

        set_raw(3'b000);
        push_window("clear_bc", 3'b011, 3'b000, LAT, LAT + 1, 1);
        tick(LAT + 1);

        // Reset in the middle of a debounce on c
        raw_c = 1'b1;
        push_window("pre_rst", 3'b000, 3'b000, 0, 4, 1);
        tick(4);
        rst_n = 1'b0;
        #1;
        push_exp("rst_abort", 3'b000, 1'b0, 1'b0);
        compare_front();
        @(negedge clk);
        rst_n = 1'b1;
        push_window("rst_resume", 3'b000, 3'b001, LAT, LAT + 1, LAT);
        tick(LAT + 1);

`ifdef VOTE_COND_HOLD_EN
        // Hold freezes a; release updates on the very next edge
        hold  = 1'b1;
        raw_a = 1'b1;
        push_window("hold", 3'b001, 3'b001, 0, 10, 1);
        tick(10);
        hold = 1'b0;
        push_window("hold_release", 3'b001, 3'b101, 1, 2, 1);
        tick(2);
`endif

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_leftover: observed %0d entries, expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
